// File: rtl/tile_map_server.sv
`default_nettype none
// ============================================================================
// Module : tile_map_server
// 16x16 tile map: comb-read/clocked-write engine port, registered render port,
//          registered player-hit query; sweeps the level layout after reset.
// Rev    : 1.0
// ============================================================================
module tile_map_server #(
    parameter logic [7:0] WALL = 8'h00,
    parameter logic [7:0] PATH = 8'h80,
    parameter logic [7:0] WOOD = 8'h10,
    parameter logic [7:0] EXPL = 8'h40
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       restart,
    input  logic [7:0] a_addr,
    input  logic       a_we,
    input  logic [7:0] a_wdata,
    output logic [7:0] a_rdata,
    input  logic [7:0] b_addr,
    output logic [7:0] b_rdata,
    input  logic [7:0] player_addr,
    output logic       player_hit,
    output logic       init_done
);

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] init_ctr;
    logic [7:0] init_ctr_next;
    logic [7:0] mem [256];
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;

    // Default level: border and even/even pillars are walls, spawn corners clear.
    function automatic logic [7:0] layout(input logic [7:0] addr);
        logic [3:0] r;
        logic [3:0] c;
        logic [1:0] diag;
        r    = addr[7:4];
        c    = addr[3:0];
        diag = r[1:0] + c[1:0];
        if (r == 4'd0 || r == 4'd15 || c == 4'd0 || c == 4'd15)
            return WALL;
        else if (!r[0] && !c[0])
            return WALL;
        else if ((r <= 4'd2 && c <= 4'd2) || (r >= 4'd13 && c >= 4'd13))
            return PATH;
        else if (diag == 2'd3)
            return WOOD;
        else
            return PATH;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= INIT;
            init_ctr <= 8'h00;
        end else begin
            state    <= state_next;
            init_ctr <= init_ctr_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_ctr_next = init_ctr;
        mem_we        = 1'b0;
        mem_waddr     = a_addr;
        mem_wdata     = a_wdata;
        case (state)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = init_ctr;
                mem_wdata = layout(init_ctr);
                if (restart) begin
                    init_ctr_next = 8'h00;
                end else if (init_ctr == 8'hFF) begin
                    state_next    = READY;
                    init_ctr_next = 8'h00;
                end else begin
                    init_ctr_next = init_ctr + 8'h01;
                end
            end
            READY: begin
                // restart wins over a concurrent engine write
                if (restart) begin
                    state_next    = INIT;
                    init_ctr_next = 8'h00;
                end else if (a_we) begin
                    mem_we = 1'b1;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    assign init_done = (state == READY);
    assign a_rdata   = (state == INIT) ? WALL : mem[a_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_rdata    <= 8'h00;
            player_hit <= 1'b0;
        end else if (state == INIT) begin
            b_rdata    <= WALL;
            player_hit <= 1'b0;
        end else begin
            b_rdata    <= mem[b_addr];
            player_hit <= (mem[player_addr] == EXPL);
        end
    end

endmodule
`default_nettype wire
